// File: rtl/host_rx_framer_pkg.sv
// Shared host-protocol parameters: opcodes, header field offsets and derived-size helpers
// used by the host receive framer and its neighbours.
package host_rx_framer_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int LEN_MSB    = 15;
  localparam int LEN_LSB    = 0;

  // Measurement rounds carried by one frame; never fewer than one.
  function automatic int meas_rounds(input int grid_width_u);
    return (grid_width_u / 2 < 1) ? 1 : grid_width_u / 2;
  endfunction

endpackage

// File: rtl/host_rx_framer.sv
// Converts framed 32-bit host words into the controller's 8-bit valid/ready byte stream,
// repairing short payloads with zero padding and dropping frames with bad headers.
module host_rx_framer
  import host_rx_framer_pkg::*;
#(
  parameter int GRID_WIDTH_X    = 4,
  parameter int GRID_WIDTH_Z    = 1,
  parameter int GRID_WIDTH_U    = 5,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_error,
  output logic [ERR_COUNT_WIDTH-1:0] error_count
);

  localparam int MEAS_ROUNDS     = meas_rounds(GRID_WIDTH_U);
  localparam int BYTES_PER_ROUND = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) >> 3;
  localparam int EXP_BYTES       = BYTES_PER_ROUND * MEAS_ROUNDS;
  localparam int EXP_WORDS       = (EXP_BYTES + 3) / 4;

  localparam logic [15:0] EXP_LEN   = 16'(EXP_BYTES);
  localparam logic [15:0] LAST_BYTE = 16'(EXP_BYTES - 1);
  localparam logic [15:0] LAST_WORD = 16'(EXP_WORDS - 1);

  typedef enum logic [2:0] {
    S_HEADER,
    S_OPCODE,
    S_PAYLOAD,
    S_PAD,
    S_DISCARD
  } state_t;

  typedef struct packed {
    state_t                     state;
    state_t                     op_next;     // where to go once the opcode byte is taken
    logic [7:0]                 out_data;
    logic                       out_valid;
    logic [31:0]                buf_word;
    logic                       buf_full;
    logic                       buf_last;    // buffered word carried s_last
    logic                       buf_final;   // buffered word is the frame's final payload word
    logic [1:0]                 byte_idx;
    logic [15:0]                emitted;
    logic [15:0]                words;
    logic                       frame_error;
    logic [ERR_COUNT_WIDTH-1:0] error_count;
    logic                       run;         // holds s_ready low for the cycle after reset
  } regs_t;

  regs_t r, r_n;

  logic        byte_free;
  logic        emit_buf;
  logic        buf_drain;
  logic        hdr_take;
  logic        word_take;
  logic        err;
  logic [7:0]  hdr_op;
  logic [15:0] hdr_len;
  logic [7:0]  buf_byte;
  logic        unused_hdr;

  assign hdr_op     = s_data[OPCODE_MSB:OPCODE_LSB];
  assign hdr_len    = s_data[LEN_MSB:LEN_LSB];
  assign unused_hdr = ^s_data[23:16];
  assign buf_byte   = r.buf_word[{r.byte_idx, 3'b000} +: 8];

  // NOTE: every field of r_n is defaulted to its current value first, so no path leaves a latch.
  always_comb begin
    r_n       = r;
    r_n.run   = 1'b1;
    err       = 1'b0;
    byte_free = !r.out_valid || out_ready;
    emit_buf  = r.buf_full && byte_free &&
                (r.state == S_PAYLOAD || (r.state == S_OPCODE && r.op_next == S_PAYLOAD));
    buf_drain = emit_buf && (r.byte_idx == 2'd3 || r.emitted == LAST_BYTE);

    unique case (r.state)
      S_HEADER:  s_ready = byte_free;
      S_OPCODE:  s_ready = (r.op_next == S_PAYLOAD) && !r.buf_full;
      // Refill in the same cycle the buffer's last byte leaves, unless the frame ends here.
      S_PAYLOAD: s_ready = !r.buf_full || (buf_drain && !r.buf_final && !r.buf_last);
      S_DISCARD: s_ready = 1'b1;
      default:   s_ready = 1'b0;
    endcase
    s_ready   = s_ready && r.run;
    hdr_take  = s_valid && s_ready && (r.state == S_HEADER);
    word_take = s_valid && s_ready && (r.state == S_PAYLOAD || r.state == S_OPCODE);

    if (byte_free) r_n.out_valid = 1'b0;

    if (r.state == S_OPCODE && out_ready) r_n.state = r.op_next;

    if (emit_buf) begin
      r_n.out_data  = buf_byte;
      r_n.out_valid = 1'b1;
      r_n.emitted   = r.emitted + 16'd1;
      r_n.byte_idx  = r.byte_idx + 2'd1;
      if (buf_drain) begin
        r_n.buf_full = 1'b0;
        r_n.byte_idx = 2'd0;
        if (r.buf_final) r_n.state = r.buf_last ? S_HEADER : S_DISCARD;
        else             r_n.state = r.buf_last ? S_PAD : S_PAYLOAD;
      end
    end

    if (word_take) begin
      r_n.buf_word  = s_data;
      r_n.buf_full  = 1'b1;
      r_n.buf_last  = s_last;
      r_n.buf_final = (r.words == LAST_WORD);
      r_n.words     = r.words + 16'd1;
      err           = (s_last != (r.words == LAST_WORD));
    end

    if (r.state == S_PAD && byte_free) begin
      r_n.out_data  = 8'h00;
      r_n.out_valid = 1'b1;
      r_n.emitted   = r.emitted + 16'd1;
      if (r.emitted == LAST_BYTE) r_n.state = S_HEADER;
    end

    if (r.state == S_DISCARD && s_valid && s_ready && s_last) r_n.state = S_HEADER;

    if (hdr_take) begin
      r_n.emitted  = 16'd0;
      r_n.words    = 16'd0;
      r_n.byte_idx = 2'd0;
      r_n.buf_full = 1'b0;
      if (hdr_op == START_DECODING_MSG && hdr_len == 16'd0 && s_last) begin
        r_n.state     = S_OPCODE;
        r_n.op_next   = S_HEADER;
        r_n.out_data  = hdr_op;
        r_n.out_valid = 1'b1;
      end else if (hdr_op == MEASUREMENT_DATA_HEADER && hdr_len == EXP_LEN) begin
        r_n.state     = S_OPCODE;
        r_n.op_next   = s_last ? S_PAD : S_PAYLOAD;
        r_n.out_data  = hdr_op;
        r_n.out_valid = 1'b1;
        err           = s_last;
      end else begin
        r_n.state = s_last ? S_HEADER : S_DISCARD;
        err       = 1'b1;
      end
    end

    r_n.frame_error = err;
    if (err && r.error_count != '1) r_n.error_count = r.error_count + 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r <= '0;
    else       r <= r_n;
  end

  assign out_data    = r.out_data;
  assign out_valid   = r.out_valid;
  assign frame_error = r.frame_error;
  assign error_count = r.error_count;

endmodule

// File: tb/tb_host_rx_framer.sv
// Self-checking bench for host_rx_framer: a default instance (2 payload bytes) and a wide
// instance (8 payload bytes, 4-bit error counter) checked against a frame-level model.
module tb_host_rx_framer;
  import host_rx_framer_pkg::*;

  localparam int EXP_A  = 2;
  localparam int EXP_B  = 8;
  localparam int EMAX_A = 65535;
  localparam int EMAX_B = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        out_ready = 1'b1;
  bit          sel = 1'b0;

  logic        a_s_ready, b_s_ready, a_out_valid, b_out_valid, a_fe, b_fe;
  logic [7:0]  a_out_data, b_out_data;
  logic [15:0] a_ec;
  logic [3:0]  b_ec;

  logic        m_s_ready, m_out_valid, m_fe;
  logic [7:0]  m_out_data;
  logic [15:0] m_ec;

  int vectors = 0;
  int miscompares = 0;
  int stall_mode = 0;
  int stall_phase = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  int         pulses = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always #5 clk = ~clk;

  host_rx_framer dut_a (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid && !sel), .s_last(s_last),
    .s_ready(a_s_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(sel ? 1'b1 : out_ready), .frame_error(a_fe), .error_count(a_ec)
  );

  host_rx_framer #(.GRID_WIDTH_X(16), .GRID_WIDTH_Z(2), .GRID_WIDTH_U(5), .ERR_COUNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid && sel), .s_last(s_last),
    .s_ready(b_s_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(sel ? out_ready : 1'b1), .frame_error(b_fe), .error_count(b_ec)
  );

  assign m_s_ready   = sel ? b_s_ready   : a_s_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_data  = sel ? b_out_data  : a_out_data;
  assign m_fe        = sel ? b_fe        : a_fe;
  assign m_ec        = sel ? {12'h000, b_ec} : a_ec;

  // Downstream ready pattern: 0 always ready, 1 random, 2 repeating 1,0,0,1, 3 stalled.
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       begin out_ready = (stall_phase % 4 == 0) || (stall_phase % 4 == 3); stall_phase++; end
      default: out_ready = 1'b0;
    endcase
  end

  // Byte collector, frame_error counter and hold-while-stalled check.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (m_out_valid !== 1'b1 || m_out_data !== prev_data) begin
          miscompares++;
          $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", m_out_valid, m_out_data, prev_data);
        end
      end
      if (m_out_valid === 1'b1 && out_ready === 1'b1) got.push_back(m_out_data);
      if (m_fe === 1'b1) pulses++;
      prev_stall = m_out_valid && !out_ready;
      prev_data  = m_out_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut(input bit which);
    sel     = which;
    s_valid = 1'b0;
    s_last  = 1'b0;
    reset   = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    got.delete();
    exp_q.delete();
    exp_err = 0;
    pulses  = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = (m_s_ready === 1'b1);
      step();
      n++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word %h not accepted in %0d cycles, required acceptance", d, n);
    end
  endtask

  // Frame-level reference: what the controller must see for one complete host frame.
  task automatic model_frame(input logic [31:0] w[$], input bit l[$], input int exp);
    logic [7:0]  op;
    int          len, n, i;
    logic [31:0] word;
    op = w[0][31:24];
    len = int'(w[0][15:0]);
    n = 0;
    if (op == START_DECODING_MSG && len == 0 && l[0]) begin
      exp_q.push_back(op);
    end else if (op == MEASUREMENT_DATA_HEADER && len == exp) begin
      exp_q.push_back(op);
      if (l[0]) exp_err++;
      else begin
        i = 1;
        while (n < exp) begin
          word = w[i];
          for (int k = 0; k < 4 && n < exp; k++) begin
            exp_q.push_back(word[8*k +: 8]);
            n++;
          end
          if (n == exp) begin
            if (!l[i]) exp_err++;
          end else if (l[i]) begin
            exp_err++;
            break;
          end
          i++;
        end
      end
      while (n < exp) begin
        exp_q.push_back(8'h00);
        n++;
      end
    end else begin
      exp_err++;
    end
  endtask

  // Kinds: 0 good, 1 start, 2 bad length, 3 bad opcode, 4 early last, 5 missing last, 6 header last.
  task automatic run_frame(input int kind, input int exp);
    logic [31:0] w[$];
    bit          l[$];
    int          nw, cut, trail;
    nw = (exp + 3) / 4;
    trail = $urandom_range(0, 2);
    case (kind)
      1: begin w.push_back({START_DECODING_MSG, 8'($urandom), 16'h0000}); l.push_back(1'b1); end
      2: begin
        w.push_back({MEASUREMENT_DATA_HEADER, 8'($urandom), 16'(exp + $urandom_range(1, 3))}); l.push_back(1'b0);
        for (int i = 0; i <= trail; i++) begin w.push_back($urandom); l.push_back(i == trail); end
      end
      3: begin w.push_back({8'hE0 | 8'($urandom_range(0, 15)), 8'($urandom), 16'($urandom)}); l.push_back(1'b1); end
      5: begin
        w.push_back({MEASUREMENT_DATA_HEADER, 8'($urandom), 16'(exp)}); l.push_back(1'b0);
        for (int i = 0; i < nw + trail + 1; i++) begin w.push_back($urandom); l.push_back(i == nw + trail); end
      end
      6: begin w.push_back({MEASUREMENT_DATA_HEADER, 8'($urandom), 16'(exp)}); l.push_back(1'b1); end
      default: begin
        cut = (kind == 4 && nw > 1) ? $urandom_range(1, nw - 1) : nw;
        w.push_back({MEASUREMENT_DATA_HEADER, 8'($urandom), 16'(exp)}); l.push_back(1'b0);
        for (int i = 0; i < cut; i++) begin w.push_back($urandom); l.push_back(i == cut - 1); end
      end
    endcase
    model_frame(w, l, exp);
    foreach (w[i]) begin
      send_word(w[i], l[i]);
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  task automatic check_stream(input string name, input int err_max);
    int n;
    int want_ec;
    n = 0;
    while (got.size() < exp_q.size() && n < 3000) begin step(); n++; end
    repeat (20) step();
    want_ec = (exp_err > err_max) ? err_max : exp_err;
    vectors++;
    if (got.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_byte[%0d]: got %h, required %h", name, i, got[i], exp_q[i]);
      end
    end
    vectors++;
    if (m_ec !== 16'(want_ec)) begin
      miscompares++;
      $display("FAIL %s_error_count: got %0d, required %0d", name, m_ec, want_ec);
    end
    vectors++;
    if (pulses != exp_err) begin
      miscompares++;
      $display("FAIL %s_frame_error: got %0d pulses, required %0d", name, pulses, exp_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    @(negedge clk);
    vectors++;
    if ({a_s_ready, a_out_valid, a_out_data, a_fe, a_ec} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: rdy=%b vld=%b data=%h fe=%b ec=%h, required all zero", a_s_ready, a_out_valid, a_out_data, a_fe, a_ec);
    end
    vectors++;
    if ({b_s_ready, b_out_valid, b_out_data, b_fe, b_ec} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: rdy=%b vld=%b data=%h fe=%b ec=%h, required all zero", b_s_ready, b_out_valid, b_out_data, b_fe, b_ec);
    end
  endtask

  task automatic test_meas_basic();
    reset_dut(1'b0);
    send_word({MEASUREMENT_DATA_HEADER, 8'h5A, 16'd2}, 1'b0);
    send_word(32'hCDEF_BBAA, 1'b1);
    exp_q = '{MEASUREMENT_DATA_HEADER, 8'hAA, 8'hBB};
    check_stream("meas_basic", EMAX_A);
  endtask

  task automatic test_start();
    reset_dut(1'b0);
    send_word({START_DECODING_MSG, 8'h00, 16'h0000}, 1'b1);
    @(negedge clk);
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_data !== START_DECODING_MSG) begin
      miscompares++;
      $display("FAIL start_latency: valid=%b data=%h one cycle after accept, required 1/%h", m_out_valid, m_out_data, START_DECODING_MSG);
    end
    @(negedge clk);
    vectors++;
    if (m_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL start_single: valid=%b after opcode taken, required 0", m_out_valid);
    end
    exp_q = '{START_DECODING_MSG};
    check_stream("start", EMAX_A);
  endtask

  task automatic test_bad_len();
    reset_dut(1'b0);
    send_word({MEASUREMENT_DATA_HEADER, 8'h00, 16'd3}, 1'b0);
    send_word(32'h1111_2222, 1'b0);
    send_word(32'h3333_4444, 1'b1);
    exp_err = 1;
    check_stream("bad_len", EMAX_A);
  endtask

  task automatic test_early_last();
    reset_dut(1'b1);
    send_word({MEASUREMENT_DATA_HEADER, 8'h00, 16'd8}, 1'b0);
    send_word(32'h4433_2211, 1'b1);
    exp_q = '{MEASUREMENT_DATA_HEADER, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_err = 1;
    check_stream("early_last", EMAX_B);
  endtask

  task automatic test_stall();
    reset_dut(1'b1);
    stall_mode = 2;
    for (int i = 0; i < 4; i++) run_frame(0, EXP_B);
    check_stream("stall", EMAX_B);
    stall_mode = 0;
  endtask

  task automatic test_random(input bit which);
    reset_dut(which);
    stall_mode = 1;
    for (int i = 0; i < 60; i++) run_frame($urandom_range(0, 6), which ? EXP_B : EXP_A);
    check_stream(which ? "random_b" : "random_a", which ? EMAX_B : EMAX_A);
    stall_mode = 0;
  endtask

  task automatic test_saturation_and_reset_mid();
    reset_dut(1'b1);
    for (int i = 0; i < 20; i++) send_word({8'hEE, 8'h00, 16'h0000}, 1'b1);
    exp_err = 20;
    check_stream("saturate", EMAX_B);
    stall_mode = 3;
    send_word({MEASUREMENT_DATA_HEADER, 8'h00, 16'd8}, 1'b0);
    send_word(32'hA5A5_5A5A, 1'b0);
    @(negedge clk);
    vectors++;
    if (m_out_valid !== 1'b1 || m_ec !== 16'd15) begin
      miscompares++;
      $display("FAIL mid_frame_setup: valid=%b ec=%0d, required valid=1 ec=15", m_out_valid, m_ec);
    end
    step();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({m_s_ready, m_out_valid, m_out_data, m_fe, m_ec} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: rdy=%b vld=%b data=%h fe=%b ec=%h, required all zero", m_s_ready, m_out_valid, m_out_data, m_fe, m_ec);
    end
    stall_mode = 0;
    reset_dut(1'b1);
    run_frame(0, EXP_B);
    check_stream("after_reset", EMAX_B);
  endtask

  initial begin
    test_reset();
    test_meas_basic();
    test_start();
    test_bad_len();
    test_early_last();
    test_stall();
    test_random(1'b0);
    test_random(1'b1);
    test_saturation_and_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
